// File: rtl/grey_pkg.sv
// Shared types and the reference binary->Gray mapping.
//   state_t     : counter FSM states
//   bin2grey()  : b ^ (b >> 1), used by the encoder and by downstream checkers
package grey_pkg;

  // Widest code the helper function handles; callers cast in and out.
  localparam int unsigned GREY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gray code of a natural-binary value.
  function automatic logic [GREY_MAX_W-1:0] bin2grey(input logic [GREY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/nature2grey_cnt_if.sv
// Valid/ready code stream between the counter and a Gray consumer.
//   out_vld : word valid (producer -> consumer)
//   out_rdy : consumer accepts word (consumer -> producer)
//   grey    : Gray code word
//   bin     : natural-binary value of the same word, for loopback checking
interface nature2grey_cnt_if #(
  parameter int unsigned WIDTH = 5
);

  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] grey;
  logic [WIDTH-1:0] bin;

  modport master (
    output out_vld,
    output grey,
    output bin,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  grey,
    input  bin,
    output out_rdy
  );

endinterface

// File: rtl/bin2grey_enc.sv
// Combinational WIDTH-bit binary -> Gray encoder.
//   bin    : natural-binary input
//   grey_c : Gray code of bin (combinational)
module bin2grey_enc
  import grey_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] grey_c
);

  assign grey_c = WIDTH'(bin2grey(GREY_MAX_W'(bin)));

endmodule

// File: rtl/nature2grey_cnt.sv
// Natural-binary up/down counter streaming its value as Gray code.
//   clk, rst_n : clock, async active-low reset
//   start      : enter RUN from IDLE/DONE, latching dir_up / mode_wrap
//   stop       : leave RUN after the next accepted word
//   dir_up     : 1 = count up, 0 = count down
//   mode_wrap  : 1 = wrap forever, 0 = stop in DONE after the terminal word
//   load       : preload count from load_val (IDLE/DONE only, wins over start)
//   load_val   : preload value
//   tc         : one-cycle pulse after the terminal word is accepted
//   busy       : FSM in RUN
//   strm       : out_vld/out_rdy/grey/bin code stream (master side)
module nature2grey_cnt
  import grey_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir_up,
  input  logic               mode_wrap,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic               tc,
  output logic               busy,
  nature2grey_cnt_if.master  strm
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] grey_q;
  logic             out_vld_q;
  logic             dir_l;
  logic             wrap_l;
  logic             stop_pend;

  logic [WIDTH-1:0] next_count_c;
  logic [WIDTH-1:0] next_grey_c;
  logic             xfer_c;
  logic             terminal_c;
  logic             stop_now_c;

  // Transfer, terminal detection and the next count value.
  always_comb begin
    xfer_c       = 1'b0;
    terminal_c   = 1'b0;
    stop_now_c   = 1'b0;
    next_count_c = count;

    xfer_c     = (state == RUN) && out_vld_q && strm.out_rdy;
    terminal_c = dir_l ? (count == MAX_VAL) : (count == '0);
    // A stop arriving together with the accepting handshake applies to that word.
    stop_now_c = stop_pend || stop;

    unique case (state)
      IDLE, DONE: begin
        if (load) begin
          next_count_c = load_val;
        end
      end
      RUN: begin
        if (xfer_c) begin
          next_count_c = dir_l ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
      end
      default: begin
        next_count_c = count;
      end
    endcase
  end

  // Gray register is fed from the same next value as the binary count.
  bin2grey_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin    (next_count_c),
    .grey_c (next_grey_c)
  );

  // Control FSM with count, code and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      grey_q    <= '0;
      out_vld_q <= 1'b0;
      tc        <= 1'b0;
      busy      <= 1'b0;
      stop_pend <= 1'b0;
      dir_l     <= 1'b1;
      wrap_l    <= 1'b1;
    end else begin
      count  <= next_count_c;
      grey_q <= next_grey_c;
      tc     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!load && start) begin
            state     <= RUN;
            out_vld_q <= 1'b1;
            busy      <= 1'b1;
            dir_l     <= dir_up;
            wrap_l    <= mode_wrap;
            stop_pend <= 1'b0;
          end
        end

        RUN: begin
          if (xfer_c) begin
            tc <= terminal_c;
            // stop outranks the one-shot DONE exit on a terminal word
            if (stop_now_c) begin
              state     <= IDLE;
              out_vld_q <= 1'b0;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else if (terminal_c && !wrap_l) begin
              state     <= DONE;
              out_vld_q <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end

        DONE: begin
          if (load) begin
            state <= IDLE;
          end else if (start) begin
            state     <= RUN;
            out_vld_q <= 1'b1;
            busy      <= 1'b1;
            dir_l     <= dir_up;
            wrap_l    <= mode_wrap;
            stop_pend <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_vld_q <= 1'b0;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
        end
      endcase
    end
  end

  assign strm.out_vld = out_vld_q;
  assign strm.grey    = grey_q;
  assign strm.bin     = count;

endmodule

// File: tb/tb_nature2grey_cnt.sv
// Bench for nature2grey_cnt: directed scenarios plus random stimulus,
// every cycle compared against a behavioural counter model.
module tb_nature2grey_cnt;

  localparam int unsigned W   = 5;
  localparam int          MOD = 1 << W;
  localparam int          MAXV = MOD - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, dir_up, mode_wrap, load;
  logic [W-1:0] load_val;
  logic         tc, busy;

  nature2grey_cnt_if #(.WIDTH(W)) strm ();

  nature2grey_cnt #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .dir_up    (dir_up),
    .mode_wrap (mode_wrap),
    .load      (load),
    .load_val  (load_val),
    .tc        (tc),
    .busy      (busy),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: running flag, count, latched direction/mode, pending stop.
  bit m_running, m_up, m_wrap, m_pend, m_tc;
  int m_cnt;
  bit m_xfer;
  logic [W-1:0] last_grey;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    int g = 0;
    for (int i = 0; i < int'(W); i++) begin
      int hi = (i == int'(W) - 1) ? 0 : ((b >> (i + 1)) & 1);
      g |= ((((b >> i) & 1) ^ hi) << i);
    end
    return g;
  endfunction

  // Downstream grey2nature behaviour: each binary bit is the XOR of all Gray bits at or above it.
  function automatic int g2n(input logic [W-1:0] g);
    int b = 0;
    bit acc = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      acc = acc ^ g[i];
      b |= (int'(acc) << i);
    end
    return b;
  endfunction

  task automatic model_reset();
    m_running = 0; m_cnt = 0; m_up = 1; m_wrap = 1; m_pend = 0; m_tc = 0; m_xfer = 0;
  endtask

  task automatic model_step();
    bit term;
    m_tc   = 0;
    m_xfer = 0;
    if (!m_running) begin
      if (load) m_cnt = int'(load_val);
      else if (start) begin
        m_running = 1; m_up = dir_up; m_wrap = mode_wrap; m_pend = 0;
      end
    end else if (strm.out_rdy) begin
      m_xfer = 1;
      term  = m_up ? (m_cnt == MAXV) : (m_cnt == 0);
      m_cnt = (m_cnt + (m_up ? 1 : -1) + MOD) % MOD;
      m_tc  = term;
      if (m_pend || stop) begin
        m_running = 0; m_pend = 0;
      end else if (term && !m_wrap) begin
        m_running = 0;
      end
    end else if (stop) begin
      m_pend = 1;
    end
  endtask

  task automatic compare();
    chk("vld",  32'(strm.out_vld), 32'(m_running));
    chk("busy", 32'(busy),         32'(m_running));
    chk("bin",  32'(strm.bin),     32'(m_cnt));
    chk("grey", 32'(strm.grey),    32'(gray_of(m_cnt)));
    chk("tc",   32'(tc),           32'(m_tc));
    chk("g2n",  32'(g2n(strm.grey)), 32'(m_cnt));
    if (m_xfer && m_running)
      chk("onebit", 32'($countones(last_grey ^ strm.grey)), 32'd1);
    last_grey = strm.grey;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic quiet();
    start = 0; stop = 0; load = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vld"},  32'(strm.out_vld), 32'd0);
    chk({tag, "_busy"}, 32'(busy),         32'd0);
    chk({tag, "_bin"},  32'(strm.bin),     32'd0);
    chk({tag, "_grey"}, 32'(strm.grey),    32'd0);
    chk({tag, "_tc"},   32'(tc),           32'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("rst_async");
    @(posedge clk);
    #1;
    compare();
    last_grey = strm.grey;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    dir_up = 1; mode_wrap = 1; load_val = '0;
    strm.out_rdy = 1'b1;
    model_reset();
    last_grey = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Up count, wrap mode, full cycle.
    start = 1; dir_up = 1; mode_wrap = 1; strm.out_rdy = 1;
    tick();
    start = 0;
    chk("t2_first", 32'(strm.grey), 32'h00);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 31) chk("t2_top_grey", 32'(strm.grey), 32'h10);
      if (k == 32) begin
        chk("t2_tc",   32'(tc),        32'd1);
        chk("t2_wrap", 32'(strm.grey), 32'h00);
      end
    end
    tick();
    chk("t2_tc_pulse", 32'(tc), 32'd0);

    // Reset in the middle of RUN with the sink ready.
    tick(); tick();
    async_reset();

    // Stall at bin=2.
    load = 1; load_val = 5'd2;
    tick();
    load = 0; start = 1; dir_up = 1; mode_wrap = 1; strm.out_rdy = 0;
    tick();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_grey", 32'(strm.grey),    32'h03);
      chk("t3_hold_bin",  32'(strm.bin),     32'd2);
      chk("t3_hold_vld",  32'(strm.out_vld), 32'd1);
    end
    strm.out_rdy = 1;
    tick();
    chk("t3_next", 32'(strm.grey), 32'h02);
    stop = 1; strm.out_rdy = 0;
    tick();
    stop = 0; strm.out_rdy = 1;
    tick();

    // One-shot down count from 3.
    load = 1; load_val = 5'd3;
    tick();
    load = 0; start = 1; dir_up = 0; mode_wrap = 0;
    tick();
    start = 0;
    repeat (3) tick();
    chk("t4_zero", 32'(strm.grey), 32'h00);
    tick();
    chk("t4_tc",   32'(tc),           32'd1);
    chk("t4_vld",  32'(strm.out_vld), 32'd0);
    chk("t4_bin",  32'(strm.bin),     32'd31);
    tick();
    chk("t4_hold", 32'(strm.bin),     32'd31);

    // Stop while stalled at bin=7.
    load = 1; load_val = 5'd7;
    tick();
    load = 0; start = 1; dir_up = 1; mode_wrap = 1; strm.out_rdy = 0;
    tick();
    start = 0; stop = 1;
    tick();
    stop = 0;
    tick();
    chk("t5_vld_hold", 32'(strm.out_vld), 32'd1);
    strm.out_rdy = 1;
    tick();
    chk("t5_vld", 32'(strm.out_vld), 32'd0);
    chk("t5_bin", 32'(strm.bin),     32'd8);

    // load ignored in RUN; load beats start in IDLE.
    start = 1; strm.out_rdy = 0;
    tick();
    start = 0; load = 1; load_val = 5'd20;
    tick();
    chk("t6_run_load", 32'(strm.bin), 32'd8);
    load = 0; stop = 1; strm.out_rdy = 1;
    tick();
    stop = 0; start = 1; load = 1; load_val = 5'd12;
    tick();
    chk("t6_idle", 32'(strm.out_vld), 32'd0);
    chk("t6_bin",  32'(strm.bin),     32'd12);
    load = 0;
    tick();
    start = 0;
    chk("t6_first", 32'(strm.grey), 32'h0A);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      start        = ($urandom_range(0, 5) == 0);
      load         = ($urandom_range(0, 9) == 0);
      load_val     = W'($urandom);
      dir_up       = 1'($urandom);
      mode_wrap    = ($urandom_range(0, 3) != 0);
      strm.out_rdy = ($urandom_range(0, 3) != 0);
      stop         = ($urandom_range(0, 7) == 0) && !strm.out_rdy;
      tick();
      if (c == 1500) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
